// File: rtl/muldiv_arbiter.sv
// Arbiter/sequencer for the shared multi-cycle multiply/divide unit: grants one issue lane at a time, runs the unit's start/abort handshake and holds hi/lo until the owner acks.
// Optional macro MULDIV_FASTZERO_EN: MULT/MULTU with a zero operand skip the unit and complete with hi = lo = 0.
module muldiv_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [1:0]   req,
    input  logic [1:0]   op0,
    input  logic [1:0]   op1,
    input  logic [W-1:0] srca0,
    input  logic [W-1:0] srcb0,
    input  logic [W-1:0] srca1,
    input  logic [W-1:0] srcb1,
    input  logic [1:0]   ack,
    output logic [1:0]   ok,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy,
    output logic         unit_start,
    output logic [1:0]   unit_op,
    output logic [W-1:0] unit_a,
    output logic [W-1:0] unit_b,
    output logic         unit_abort,
    input  logic         unit_done,
    input  logic [W-1:0] unit_hi,
    input  logic [W-1:0] unit_lo
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

    state_t       state_reg, state_next;
    logic         owner_reg;
    logic [1:0]   op_reg;
    logic [W-1:0] a_reg, b_reg;
    logic [W-1:0] hi_reg, lo_reg;
    logic         start_pend_reg;

    logic         grant_lane;
    logic [1:0]   grant_op;
    logic [W-1:0] grant_a, grant_b;
    logic         grant_zero;
    logic         grant;

    // Older lane (bit 0) wins whenever it is requesting.
    always_comb begin
        grant_lane = ~req[0];
        grant_op   = grant_lane ? op1   : op0;
        grant_a    = grant_lane ? srca1 : srca0;
        grant_b    = grant_lane ? srcb1 : srcb0;
`ifdef MULDIV_FASTZERO_EN
        grant_zero = ~grant_op[1] && ((grant_a == '0) || (grant_b == '0));
`else
        grant_zero = 1'b0;
`endif
    end

    assign grant = (state_reg == IDLE) && (state_next != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // A done pulse in the start cycle is ignored: the unit needs at least one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (!flush && (req != 2'b00)) state_next = grant_zero ? HOLD : RUN;
            RUN: begin
                if (flush)                                state_next = IDLE;
                else if (unit_done && !start_pend_reg)    state_next = HOLD;
            end
            HOLD: begin
                if (flush)                                state_next = IDLE;
                else if (ack[owner_reg])                  state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_reg      <= 1'b0;
            op_reg         <= 2'b00;
            a_reg          <= '0;
            b_reg          <= '0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            start_pend_reg <= 1'b0;
        end else begin
            start_pend_reg <= 1'b0;
            if (grant) begin
                owner_reg      <= grant_lane;
                op_reg         <= grant_op;
                a_reg          <= grant_a;
                b_reg          <= grant_b;
                hi_reg         <= '0;
                lo_reg         <= '0;
                start_pend_reg <= ~grant_zero;
            end else if ((state_reg == RUN) && (state_next == HOLD)) begin
                hi_reg <= unit_hi;
                lo_reg <= unit_lo;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ok
            assign ok[gi] = (state_reg == HOLD) && (owner_reg == 1'(gi));
        end
    endgenerate

    always_comb begin
        busy       = (state_reg != IDLE);
        unit_start = 1'b0;
        unit_abort = 1'b0;
        unit_op    = 2'b00;
        unit_a     = '0;
        unit_b     = '0;
        hi         = '0;
        lo         = '0;
        if (state_reg == RUN) begin
            unit_start = start_pend_reg;
            unit_abort = flush;
            unit_op    = op_reg;
            unit_a     = a_reg;
            unit_b     = b_reg;
        end
        if (state_reg == HOLD) begin
            hi = hi_reg;
            lo = lo_reg;
        end
    end

endmodule
